// File: rtl/down_counter_ctrl_pkg.sv
// Shared types and defaults for the down-counter sequencing controller.
package down_counter_ctrl_pkg;

  localparam int STATE_W          = 2;
  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PRESCALE = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/down_counter_ctrl_tick_gen.sv
// Prescaler: counts clk cycles while enabled; tick marks the last cycle of a count step.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] phase;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PS_W'(1);
    end
  end

  // Meaningful only when en is high; the caller qualifies it with its own run condition.
  assign tick = (phase == LAST);

endmodule

// File: rtl/down_counter_ctrl.sv
// Programmable down-counter timer: load/start/pause/stop sequencing, terminal-count pulse, auto-reload.
module down_counter_ctrl
  import down_counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] RESET_COUNT = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] count_nxt, eff_val;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             tick_en, tick_clr, tick;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      reload  <= RESET_COUNT;
      count   <= RESET_COUNT;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      reload  <= reload_nxt;
      count   <= count_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      cfg_err <= err_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    reload_nxt = reload;
    count_nxt  = count;
    eff_val    = reload;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    tick_en    = 1'b0;
    tick_clr   = 1'b0;

    if (stop) begin
      state_nxt = IDLE;
      count_nxt = reload;
      tick_clr  = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cfg_load) begin
            reload_nxt = cfg_val;
            count_nxt  = cfg_val;
            eff_val    = cfg_val;
            state_nxt  = IDLE;
          end
          // A start in the same cycle as a load counts down from the freshly loaded value.
          if (start) begin
            tick_clr  = 1'b1;
            count_nxt = eff_val;
            if (eff_val == '0) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end

        RUN: begin
          err_nxt = cfg_load;
          if (pause && !cfg_load && !start) begin
            state_nxt = PAUSE;
          end else begin
            tick_en = 1'b1;
            if (tick) begin
              if (count == WIDTH'(1)) begin
                done_nxt = 1'b1;
                if (auto_reload) begin
                  count_nxt = reload;
                end else begin
                  count_nxt = '0;
                  state_nxt = DONE;
                end
              end else if (count != '0) begin
                count_nxt = count - WIDTH'(1);
              end
            end
          end
        end

        PAUSE: begin
          if (cfg_load) begin
            err_nxt = 1'b1;
          end else if (start) begin
            state_nxt = RUN;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
  end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Randomised and directed bench: two instances (PRESCALE 1 and 4) checked against a mode/phase model.
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load, start, pause, stop, auto_reload;
  logic [3:0] cfg_val;
  logic [3:0] count1, count4;
  logic       busy1, busy4, done1, done4, err1, err4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_val(cfg_val),
    .auto_reload(auto_reload), .start(start), .pause(pause), .stop(stop),
    .count(count1), .busy(busy1), .done(done1), .cfg_err(err1)
  );

  down_counter_ctrl #(.WIDTH(4), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_val(cfg_val),
    .auto_reload(auto_reload), .start(start), .pause(pause), .stop(stop),
    .count(count4), .busy(busy4), .done(done4), .cfg_err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer mode, count, reload and cycles elapsed in the current count step.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int ps[2] = '{1, 4};
  int m_mode[2], m_cnt[2], m_rel[2], m_phase[2];
  bit e_done[2], e_err[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_cnt[i] = 15; m_rel[i] = 15; m_phase[i] = 0;
      e_done[i] = 0; e_err[i] = 0;
    end
  endfunction

  function automatic void advance(int i);
    m_phase[i]++;
    if (m_phase[i] == ps[i]) begin
      m_phase[i] = 0;
      if (m_cnt[i] == 1) begin
        e_done[i] = 1;
        if (auto_reload) m_cnt[i] = m_rel[i];
        else begin m_cnt[i] = 0; m_mode[i] = M_DONE; end
      end else if (m_cnt[i] > 0) begin
        m_cnt[i]--;
      end
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      e_done[i] = 0; e_err[i] = 0;
      if (stop) begin
        m_mode[i] = M_IDLE; m_cnt[i] = m_rel[i]; m_phase[i] = 0;
      end else if (m_mode[i] == M_IDLE || m_mode[i] == M_DONE) begin
        if (cfg_load) begin
          m_rel[i] = int'(cfg_val); m_cnt[i] = int'(cfg_val); m_mode[i] = M_IDLE;
        end
        if (start) begin
          m_phase[i] = 0;
          if (m_rel[i] == 0) begin m_mode[i] = M_DONE; m_cnt[i] = 0; e_done[i] = 1; end
          else begin m_mode[i] = M_RUN; m_cnt[i] = m_rel[i]; end
        end
      end else if (cfg_load) begin
        e_err[i] = 1;
        if (m_mode[i] == M_RUN) advance(i);
      end else if (start) begin
        if (m_mode[i] == M_PAUSE) m_mode[i] = M_RUN;
        else advance(i);
      end else if (pause && m_mode[i] == M_RUN) begin
        m_mode[i] = M_PAUSE;
      end else if (m_mode[i] == M_RUN) begin
        advance(i);
      end
    end
  endfunction

  task automatic compare_all();
    check("p1_count", count1, m_cnt[0]);
    check("p1_busy",  busy1,  (m_mode[0] == M_RUN || m_mode[0] == M_PAUSE));
    check("p1_done",  done1,  e_done[0]);
    check("p1_err",   err1,   e_err[0]);
    check("p4_count", count4, m_cnt[1]);
    check("p4_busy",  busy4,  (m_mode[1] == M_RUN || m_mode[1] == M_PAUSE));
    check("p4_done",  done4,  e_done[1]);
    check("p4_err",   err4,   e_err[1]);
  endtask

  // One clock: model consumes the inputs present at the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    cfg_load = 0; start = 0; pause = 0; stop = 0;
  endtask

  initial begin
    int last, n_done, ticks;
    bit seen;

    reset = 1; cfg_load = 0; start = 0; pause = 0; stop = 0; auto_reload = 0; cfg_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count1, 4'hF);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    compare_all();
    @(negedge clk) reset = 0;
    step();

    // One-shot countdown from 3.
    cfg_load = 1; cfg_val = 4'd3; step();
    start = 1; step();
    check("os_start_count", count1, 3);
    check("os_start_busy", busy1, 1);
    for (int k = 2; k >= 0; k--) begin
      step();
      check("os_seq", count1, k);
    end
    check("os_done", done1, 1);
    check("os_busy_drop", busy1, 0);
    step();
    check("os_done_1clk", done1, 0);
    check("os_hold_zero", count1, 0);

    // Periodic mode, reload 2, prescale 4.
    stop = 1; step();
    cfg_load = 1; cfg_val = 4'd2; auto_reload = 1; step();
    start = 1; step();
    last = 0; n_done = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (done4) begin
        n_done++;
        if (last > 0) check("ar_period", k - last, 8);
        last = k;
      end
    end
    check("ar_pulses", n_done, 4);
    auto_reload = 0; stop = 1; step();

    // Pause at 5 for 10 clocks, then resume.
    cfg_load = 1; cfg_val = 4'd9; step();
    start = 1; step();
    check("pr_start", count1, 9);
    repeat (4) step();
    check("pr_at5", count1, 5);
    pause = 1; step();
    check("pr_paused", count1, 5);
    check("pr_busy", busy1, 1);
    repeat (10) step();
    check("pr_held", count1, 5);
    start = 1; step();
    check("pr_resume", count1, 5);
    ticks = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      ticks++;
      if (done1) seen = 1;
    end
    check("pr_done_seen", seen, 1);
    check("pr_ticks_after", ticks, 5);

    // Rejected load while running, then stop beating start.
    cfg_load = 1; cfg_val = 4'd6; start = 1; step();
    check("er_load_start", count1, 6);
    cfg_load = 1; cfg_val = 4'd2; step();
    check("er_cfg_err", err1, 1);
    check("er_count", count1, 5);
    step();
    check("er_err_1clk", err1, 0);
    stop = 1; start = 1; step();
    check("er_stop_busy", busy1, 0);
    check("er_stop_count", count1, 6);

    // Zero load with start, then async reset mid-run.
    cfg_load = 1; cfg_val = 4'd0; start = 1; step();
    check("z_done", done1, 1);
    check("z_busy", busy1, 0);
    step();
    check("z_done_1clk", done1, 0);
    cfg_load = 1; cfg_val = 4'd7; start = 1; step();
    repeat (3) step();
    check("ar_pre_count", count1, 4);
    #2 reset = 1;
    #1;
    model_reset();
    check("async_count", count1, 4'hF);
    check("async_busy", busy1, 0);
    check("async_done", done1, 0);
    compare_all();
    @(negedge clk) reset = 0;
    step();

    // Random command mix.
    for (int k = 0; k < 600; k++) begin
      stop     = ($urandom_range(31, 0) == 0);
      cfg_load = ($urandom_range(15, 0) == 0);
      start    = ($urandom_range(7, 0) == 0);
      pause    = ($urandom_range(15, 0) == 0);
      cfg_val  = 4'($urandom_range(15, 0));
      if ($urandom_range(49, 0) == 0) auto_reload = ~auto_reload;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
